// File: rtl/sram_ot_pkg.sv
// -----------------------------------------------------------------------------
// sram_ot_pkg
// Shared constants and types for the output-feature SRAM controller.
//   WORD_AMOUNT   : words per 56x56 output map (one word per pixel)
//   BIT_PER_WORD  : signed partial-sum / SRAM word width
//   ADDR_W        : SRAM address width
//   SAT_MAX/MIN   : saturation limits of a BIT_PER_WORD signed word
//   state_t       : controller states
// Optional build macro used by the controller: SRAM_OT_RELU_EN.
// -----------------------------------------------------------------------------
package sram_ot_pkg;

    localparam int WORD_AMOUNT  = 3136;
    localparam int BIT_PER_WORD = 25;
    localparam int ADDR_W       = $clog2(WORD_AMOUNT);
    localparam int SUM_W        = BIT_PER_WORD + 1;

    localparam logic [BIT_PER_WORD-1:0] SAT_MAX = {1'b0, {(BIT_PER_WORD-1){1'b1}}};
    localparam logic [BIT_PER_WORD-1:0] SAT_MIN = {1'b1, {(BIT_PER_WORD-1){1'b0}}};
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(WORD_AMOUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_ACC_RD,
        ST_ACC_WR,
        ST_DRN_RD,
        ST_DRN_HOLD
    } state_t;

endpackage

// File: rtl/sram_ot_sat_add.sv
// -----------------------------------------------------------------------------
// sram_ot_sat_add
// Combinational signed saturating adder with an optional ReLU stage.
// Ports:
//   a, b : signed BIT_PER_WORD operands
//   relu : when 1, a negative saturated result is replaced by 0
//   y    : saturated (and optionally rectified) result
// -----------------------------------------------------------------------------
module sram_ot_sat_add
    import sram_ot_pkg::*;
(
    input  logic [BIT_PER_WORD-1:0] a,
    input  logic [BIT_PER_WORD-1:0] b,
    input  logic                    relu,
    output logic [BIT_PER_WORD-1:0] y
);

    logic [SUM_W-1:0]        sum;
    logic [BIT_PER_WORD-1:0] sat;

    always_comb begin
        // One guard bit is enough: the sum of two BIT_PER_WORD values
        // always fits in SUM_W bits.
        sum = {a[BIT_PER_WORD-1], a} + {b[BIT_PER_WORD-1], b};

        // The two top bits disagree exactly when the result left the
        // BIT_PER_WORD range; the guard bit tells the direction.
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            sat = sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sat = sum[BIT_PER_WORD-1:0];
        end

        y = (relu && sat[BIT_PER_WORD-1]) ? '0 : sat;
    end

endmodule

// File: rtl/sram_ot_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ot_ctrl
// Sequencing controller for the single-port output-feature SRAM. Accumulates
// raster-ordered partial sums over several channel passes (overwrite on the
// first pass, read-modify-write afterwards) and drains the finished map.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   pass_start, first_pass, last_pass : pass launch and its sampled mode bits
//   ps_valid/ps_ready/ps_data         : partial-sum stream input
//   drain_start                       : launch a full-map drain
//   out_valid/out_ready/out_data/out_last : drain stream output
//   busy, pass_done                   : status
//   sram_we/addr/din/dout/final_flag  : SRAM port (1-cycle read latency)
// Build macro: SRAM_OT_RELU_EN -- when defined, values written during a
// last_pass pass are clamped at 0 when negative.
// -----------------------------------------------------------------------------
module sram_ot_ctrl
    import sram_ot_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pass_start,
    input  logic                    first_pass,
    input  logic                    last_pass,
    input  logic                    ps_valid,
    output logic                    ps_ready,
    input  logic [BIT_PER_WORD-1:0] ps_data,
    input  logic                    drain_start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIT_PER_WORD-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    pass_done,
    output logic                    sram_we,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [BIT_PER_WORD-1:0] sram_din,
    input  logic [BIT_PER_WORD-1:0] sram_dout,
    output logic                    sram_final_flag
);

    state_t                  state_reg, state_next;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    final_flag_reg;
    logic                    pass_done_reg;
    logic                    acc_first_reg;
    logic [BIT_PER_WORD-1:0] hold_reg;
    logic                    drn_first_reg;
    logic                    out_valid_reg;
    logic [BIT_PER_WORD-1:0] out_data_reg;

    logic                    ps_hs;
    logic                    drn_hs;
    logic                    last_word;
    logic                    relu_active;
    logic [BIT_PER_WORD-1:0] add_a;
    logic [BIT_PER_WORD-1:0] add_y;

`ifdef SRAM_OT_RELU_EN
    assign relu_active = final_flag_reg;
`else
    assign relu_active = 1'b0;
`endif

    assign last_word = (addr_reg == LAST_ADDR);
    assign ps_ready  = (state_reg == ST_WR) || (state_reg == ST_ACC_WR);
    assign ps_hs     = ps_valid && ps_ready;
    assign drn_hs    = (state_reg == ST_DRN_HOLD) && out_valid_reg && out_ready;

    // The SRAM word arrives only in the first ACC_WR cycle; later stall
    // cycles use the copy kept in hold_reg. First passes add nothing.
    always_comb begin
        add_a = '0;
        if (state_reg == ST_ACC_WR) begin
            add_a = acc_first_reg ? sram_dout : hold_reg;
        end
    end

    sram_ot_sat_add u_sat_add (
        .a    (add_a),
        .b    (ps_data),
        .relu (relu_active),
        .y    (add_y)
    );

    assign sram_we         = ps_hs;
    assign sram_addr       = addr_reg;
    assign sram_din        = ps_hs ? add_y : '0;
    assign sram_final_flag = final_flag_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign pass_done       = pass_done_reg;
    assign out_valid       = out_valid_reg;
    assign out_data        = out_data_reg;
    assign out_last        = out_valid_reg && last_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                // pass_start has priority; a simultaneous drain_start is lost.
                if (pass_start) begin
                    state_next = first_pass ? ST_WR : ST_ACC_RD;
                end else if (drain_start) begin
                    state_next = ST_DRN_RD;
                end
            end
            ST_WR: begin
                if (ps_hs && last_word) state_next = ST_IDLE;
            end
            ST_ACC_RD: begin
                state_next = ST_ACC_WR;
            end
            ST_ACC_WR: begin
                if (ps_hs) state_next = last_word ? ST_IDLE : ST_ACC_RD;
            end
            ST_DRN_RD: begin
                state_next = ST_DRN_HOLD;
            end
            ST_DRN_HOLD: begin
                if (drn_hs) state_next = last_word ? ST_IDLE : ST_DRN_RD;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= '0;
            final_flag_reg <= 1'b0;
            pass_done_reg  <= 1'b0;
            acc_first_reg  <= 1'b0;
            hold_reg       <= '0;
            drn_first_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            pass_done_reg <= ps_hs && last_word;
            acc_first_reg <= (state_reg == ST_ACC_RD);
            drn_first_reg <= (state_reg == ST_DRN_RD);

            if ((state_reg == ST_IDLE) && pass_start) begin
                final_flag_reg <= last_pass;
            end

            if ((state_reg == ST_ACC_WR) && acc_first_reg) begin
                hold_reg <= sram_dout;
            end

            if (ps_hs || drn_hs) begin
                addr_reg <= last_word ? '0 : addr_reg + 1'b1;
            end

            // Drain word is captured on the first DRN_HOLD cycle and then
            // presented until accepted.
            if ((state_reg == ST_DRN_HOLD) && drn_first_reg) begin
                out_data_reg  <= sram_dout;
                out_valid_reg <= 1'b1;
            end else if (drn_hs) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_ot_ctrl.sv
`timescale 1ns/1ps
module tb_sram_ot_ctrl;

    localparam int     N    = 3136;
    localparam longint MAXV = 16777215;
    localparam longint MINV = -16777216;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pass_start = 1'b0;
    logic        first_pass = 1'b0;
    logic        last_pass = 1'b0;
    logic        ps_valid = 1'b0;
    logic        ps_ready;
    logic [24:0] ps_data = '0;
    logic        drain_start = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] out_data;
    logic        out_last;
    logic        busy;
    logic        pass_done;
    logic        sram_we;
    logic [11:0] sram_addr;
    logic [24:0] sram_din;
    logic [24:0] sram_dout = '0;
    logic        sram_final_flag;

    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [24:0] pre_data = '0;
    logic [24:0] mem [0:N-1];
    longint      exp_mem [0:N-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_ot_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pass_start      (pass_start),
        .first_pass      (first_pass),
        .last_pass       (last_pass),
        .ps_valid        (ps_valid),
        .ps_ready        (ps_ready),
        .ps_data         (ps_data),
        .drain_start     (drain_start),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .pass_done       (pass_done),
        .sram_we         (sram_we),
        .sram_addr       (sram_addr),
        .sram_din        (sram_din),
        .sram_dout       (sram_dout),
        .sram_final_flag (sram_final_flag)
    );

    // Single-port SRAM model, read-first, 1-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint sat(input longint s, input bit relu);
        longint r;
        r = s;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    function automatic longint data_for(input int mode, input int a);
        case (mode)
            0: return longint'(a);
            1: return (a == 100) ? 100 : ((a == 101) ? -1 : 5);
            2: return (a == 0) ? -50 : 0;
            3: return longint'(3 * a);
            default: return 7;
        endcase
    endfunction

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_ps_ready"}, ps_ready, 0);
        chk({pfx, "_we"}, sram_we, 0);
        chk({pfx, "_addr"}, sram_addr, 0);
        chk({pfx, "_din"}, sram_din, 0);
        chk({pfx, "_pass_done"}, pass_done, 0);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_out_data"}, out_data, 0);
        chk({pfx, "_out_last"}, out_last, 0);
        chk({pfx, "_final_flag"}, sram_final_flag, 0);
    endtask

    task automatic preload(input int a, input longint v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 12'(a); pre_data = 25'(v);
        @(negedge clk);
        pre_we = 1'b0;
        exp_mem[a] = v;
    endtask

    // One pass; inputs driven at negedge, outputs observed 1 ns later.
    task automatic run_pass(input bit first, input bit last, input int mode,
                            input int abort_at, output bit aborted);
        int writes = 0, cyc = 0, last_we_cyc = -1, a;
        bit prev_we = 1'b0, relu;
        longint d, e;
        aborted = 1'b0;
`ifdef SRAM_OT_RELU_EN
        relu = last;
`else
        relu = 1'b0;
`endif
        @(negedge clk);
        pass_start = 1'b1; first_pass = first; last_pass = last;
        drain_start = (mode == 2);
        ps_valid = 1'b0;
        @(negedge clk);
        pass_start = 1'b0; first_pass = 1'b0; last_pass = 1'b0;
        while (writes < N && cyc < 20000) begin
            if (cyc > 0) @(negedge clk);
            a = int'(sram_addr);
            d = data_for(mode, a);
            ps_data = 25'(d);
            ps_valid = (mode == 1 && a >= 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
            drain_start = (mode == 1 && a == 500);
            #1;
            if (abort_at >= 0 && a == abort_at) begin
                aborted = 1'b1;
                ps_valid = 1'b0;
                break;
            end
            if (prev_we && !first) chk("acc_rd_ps_ready", ps_ready, 0);
            chk("final_flag", sram_final_flag, last);
            chk("pass_out_valid", out_valid, 0);
            chk("pass_done_early", pass_done, 0);
            if (sram_we) begin
                chk("we_addr", sram_addr, writes);
                e = first ? sat(d, relu) : sat(exp_mem[a] + d, relu);
                chk("we_din", longint'($signed(sram_din)), e);
                exp_mem[a] = e;
                if (last_we_cyc >= 0 && (first || a < 2000))
                    chk("we_gap", cyc - last_we_cyc, first ? 1 : 2);
                last_we_cyc = cyc;
                writes++;
            end
            prev_we = sram_we;
            cyc++;
        end
        drain_start = 1'b0;
        if (!aborted) begin
            chk("pass_writes", writes, N);
            if (mode == 0) chk("first_pass_cycles", last_we_cyc, N - 1);
            @(negedge clk);
            ps_valid = 1'b0;
            #1;
            chk("pass_done_pulse", pass_done, 1);
            chk("pass_idle_busy", busy, 0);
            @(negedge clk);
            #1;
            chk("pass_done_clear", pass_done, 0);
            $display("pass mode=%0d first=%0d last=%0d: %0d writes in %0d cycles",
                     mode, first, last, writes, cyc);
        end else begin
            $display("pass mode=%0d aborted at address %0d", mode, abort_at);
        end
    endtask

    task automatic run_drain();
        int idx = 0, stall = 0, cyc = 0;
        bit prev_stall = 1'b0;
        logic [24:0] prev_data = '0;
        @(negedge clk);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        while (idx < N && cyc < 40000) begin
            out_ready = !(idx == 7 && stall < 10);
            #1;
            chk("drn_we", sram_we, 0);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
                chk("drn_data", longint'($signed(out_data)), exp_mem[idx]);
                chk("drn_last", out_last, idx == N - 1);
                prev_stall = !out_ready;
                prev_data = out_data;
                if (!out_ready) stall++;
                else idx++;
            end else begin
                chk("drn_last_novalid", out_last, 0);
                prev_stall = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drn_words", idx, N);
        chk("drn_stall_cycles", stall, 10);
        #1;
        chk("drn_idle_busy", busy, 0);
        $display("drain: %0d words in %0d cycles, %0d stall cycles", idx, cyc, stall);
    endtask

    initial begin
        bit ab;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("post_reset");

        // First pass: data = address, then drain 0..3135
        run_pass(1'b1, 1'b0, 0, -1, ab);
        run_drain();

        // Accumulate pass with saturation words and backpressure
        preload(100, 16777200);
        preload(101, -16777216);
        run_pass(1'b0, 1'b0, 1, -1, ab);
        chk("sat_pos_word", longint'($signed(mem[100])), 16777215);
        chk("sat_neg_word", longint'($signed(mem[101])), -16777216);
        chk("acc_word_5", longint'($signed(mem[5])), 10);
        run_drain();

        // Abort mid-accumulate at address 1000 with an asynchronous reset
        run_pass(1'b0, 1'b0, 4, 1000, ab);
        chk("abort_reached", ab, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(1'b1, 1'b0, 3, -1, ab);
        chk("rerun_word_1000", longint'($signed(mem[1000])), 3000);

        // Last pass: stored 20 plus -50, pass_start and drain_start together
        preload(0, 20);
        run_pass(1'b0, 1'b1, 2, -1, ab);
`ifdef SRAM_OT_RELU_EN
        chk("last_pass_word0", longint'($signed(mem[0])), 0);
`else
        chk("last_pass_word0", longint'($signed(mem[0])), -30);
`endif
        chk("final_flag_held", sram_final_flag, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
